// File: rtl/alu_operand_stage_if.sv
// Package and interface for the ALU operand stage.
//
// alu_operand_stage_pkg : ALU operation encoding shared by decode, this stage
//                         and the ALU.
// alu_operand_stage_if  : all non-clock signals of the stage.
//   master modport : environment view. Decode, forwarding sources and the
//                    ALU-side consumer drive the stage through it.
//   slave modport  : stage view. The stage takes decoded ops, forwarding
//                    data, flush and out_ready_i, and drives in_ready_o
//                    together with the registered ALU-side op.
//   Signals: flush_i, decode handshake/payload (in_*), MEM/WB forwarding
//            (fwd_*), ALU-side handshake/payload (out_*, alu_op_o, in1_o,
//            in2_o, rd_addr_o).

package alu_operand_stage_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_op_t;

endpackage

interface alu_operand_stage_if
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);

    logic              flush_i;

    logic              in_valid_i;
    logic              in_ready_o;
    alu_op_t           in_alu_op_i;
    logic [REG_AW-1:0] in_rs1_addr_i;
    logic [REG_AW-1:0] in_rs2_addr_i;
    logic [XLEN-1:0]   in_rs1_data_i;
    logic [XLEN-1:0]   in_rs2_data_i;
    logic [XLEN-1:0]   in_pc_i;
    logic [XLEN-1:0]   in_imm_i;
    logic [1:0]        in_in1_sel_i;
    logic [1:0]        in_in2_sel_i;
    logic [REG_AW-1:0] in_rd_addr_i;

    logic              fwd_mem_en_i;
    logic [REG_AW-1:0] fwd_mem_rd_i;
    logic [XLEN-1:0]   fwd_mem_data_i;
    logic              fwd_wb_en_i;
    logic [REG_AW-1:0] fwd_wb_rd_i;
    logic [XLEN-1:0]   fwd_wb_data_i;

    logic              out_valid_o;
    logic              out_ready_i;
    alu_op_t           alu_op_o;
    logic [XLEN-1:0]   in1_o;
    logic [XLEN-1:0]   in2_o;
    logic [REG_AW-1:0] rd_addr_o;

    modport master (
        output flush_i,
        output in_valid_i, in_alu_op_i, in_rs1_addr_i, in_rs2_addr_i,
        output in_rs1_data_i, in_rs2_data_i, in_pc_i, in_imm_i,
        output in_in1_sel_i, in_in2_sel_i, in_rd_addr_i,
        output fwd_mem_en_i, fwd_mem_rd_i, fwd_mem_data_i,
        output fwd_wb_en_i, fwd_wb_rd_i, fwd_wb_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, alu_op_o, in1_o, in2_o, rd_addr_o
    );

    modport slave (
        input  flush_i,
        input  in_valid_i, in_alu_op_i, in_rs1_addr_i, in_rs2_addr_i,
        input  in_rs1_data_i, in_rs2_data_i, in_pc_i, in_imm_i,
        input  in_in1_sel_i, in_in2_sel_i, in_rd_addr_i,
        input  fwd_mem_en_i, fwd_mem_rd_i, fwd_mem_data_i,
        input  fwd_wb_en_i, fwd_wb_rd_i, fwd_wb_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, alu_op_o, in1_o, in2_o, rd_addr_o
    );

endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: resolves in1/in2 for the ALU from register data (with
// MEM/WB forwarding), PC, immediate and constants, then registers the op
// behind a valid/ready handshake with a 2-entry skid buffer (OUT + SKID).
//
// Ports:
//   clk_i    : clock, all state on the rising edge
//   reset_ni : asynchronous active-low reset
//   bus      : alu_operand_stage_if.slave. Carries flush, the decode-side
//              handshake/payload, forwarding, and the ALU-side
//              handshake/payload.
//
// in_ready_o is decoded from the state register only. That keeps
// out_ready_i from reaching in_ready_o through a combinational path.

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        alu_op_t           alu_op;
        logic [XLEN-1:0]   in1;
        logic [XLEN-1:0]   in2;
        logic [REG_AW-1:0] rd;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // OUT empty,  SKID empty
        ST_ONE   = 2'd1,   // OUT valid,  SKID empty
        ST_FULL  = 2'd2    // OUT valid,  SKID valid
    } state_t;

    localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

    state_t   state_q;
    state_t   state_next;
    payload_t in_payload;
    payload_t out_q;
    payload_t skid_q;
    logic     accept;
    logic     transfer;
    logic     load_out_from_in;
    logic     load_out_from_skid;
    logic     load_skid;

    // MEM beats WB. x0 is hard-wired to zero whatever the regfile or the
    // forwarding sources report.
    function automatic logic [XLEN-1:0] resolve_src(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_data,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_rd,
        input logic [XLEN-1:0]   mem_data,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data
    );
        logic [XLEN-1:0] value;
        if (rs == '0) begin
            value = '0;
        end else if (mem_en && (mem_rd == rs)) begin
            value = mem_data;
        end else if (wb_en && (wb_rd == rs)) begin
            value = wb_data;
        end else begin
            value = rf_data;
        end
        return value;
    endfunction

    // ------------------------------------------------------------------
    // Operand resolution (sampled in the accept cycle)
    // ------------------------------------------------------------------
    always_comb begin
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can leave it unassigned and infer a latch.
        in_payload        = '0;
        in_payload.alu_op = bus.in_alu_op_i;
        in_payload.rd     = bus.in_rd_addr_i;

        src1 = resolve_src(bus.in_rs1_addr_i, bus.in_rs1_data_i,
                           bus.fwd_mem_en_i, bus.fwd_mem_rd_i, bus.fwd_mem_data_i,
                           bus.fwd_wb_en_i, bus.fwd_wb_rd_i, bus.fwd_wb_data_i);
        src2 = resolve_src(bus.in_rs2_addr_i, bus.in_rs2_data_i,
                           bus.fwd_mem_en_i, bus.fwd_mem_rd_i, bus.fwd_mem_data_i,
                           bus.fwd_wb_en_i, bus.fwd_wb_rd_i, bus.fwd_wb_data_i);

        unique case (bus.in_in1_sel_i)
            2'd0:    in_payload.in1 = src1;
            2'd1:    in_payload.in1 = bus.in_pc_i;
            default: in_payload.in1 = '0;        // zero and reserved
        endcase

        unique case (bus.in_in2_sel_i)
            2'd0:    in_payload.in2 = src2;
            2'd1:    in_payload.in2 = bus.in_imm_i;
            2'd2:    in_payload.in2 = CONST_FOUR;
            default: in_payload.in2 = '0;        // reserved
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    assign accept   = bus.in_valid_i && bus.in_ready_o;
    assign transfer = bus.out_valid_o && bus.out_ready_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // that every register samples the values from before the edge.
        if (!reset_ni) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (bus.flush_i) begin
            state_next = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (accept) state_next = ST_ONE;
                ST_ONE: begin
                    if (accept && !transfer)      state_next = ST_FULL;
                    else if (!accept && transfer) state_next = ST_EMPTY;
                end
                ST_FULL:  if (transfer) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.out_valid_o    = (state_q != ST_EMPTY);
        bus.in_ready_o     = (state_q != ST_FULL);
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (!bus.flush_i) begin
            unique case (state_q)
                ST_EMPTY: load_out_from_in = accept;
                ST_ONE: begin
                    load_out_from_in = accept && transfer;
                    load_skid        = accept && !transfer;
                end
                ST_FULL:  load_out_from_skid = transfer;
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_q <= '{alu_op: ALU_OP_ADD, in1: '0, in2: '0, rd: '0};
        end else if (load_out_from_in) begin
            out_q <= in_payload;
        end else if (load_out_from_skid) begin
            out_q <= skid_q;
        end
    end

    // NOTE: SKID holds data only. Its valid bit lives in the FSM, which is
    // reset, so the data register is deliberately left without a reset.
    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_q <= in_payload;
        end
    end

    assign bus.alu_op_o  = out_q.alu_op;
    assign bus.in1_o     = out_q.in1;
    assign bus.in2_o     = out_q.in2;
    assign bus.rd_addr_o = out_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// at that point too, which is well away from the next edge.

module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic clk_i;
    logic reset_ni;
    int   total;
    int   bad;

    alu_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input alu_op_t op,
                          input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [4:0] rd);
        bus.in_alu_op_i   = op;
        bus.in_rs1_addr_i = rs1;
        bus.in_rs1_data_i = d1;
        bus.in_rs2_addr_i = rs2;
        bus.in_rs2_data_i = d2;
        bus.in_in1_sel_i  = s1;
        bus.in_in2_sel_i  = s2;
        bus.in_pc_i       = pc;
        bus.in_imm_i      = imm;
        bus.in_rd_addr_i  = rd;
    endtask

    task automatic set_fwd(input logic me, input logic [4:0] mrd, input logic [31:0] md,
                           input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        bus.fwd_mem_en_i   = me;
        bus.fwd_mem_rd_i   = mrd;
        bus.fwd_mem_data_i = md;
        bus.fwd_wb_en_i    = we;
        bus.fwd_wb_rd_i    = wrd;
        bus.fwd_wb_data_i  = wd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_ni        = 1'b0;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        set_op(ALU_OP_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_in1", bus.in1_o, 32'h0);
        check("rst_in2", bus.in2_o, 32'h0);
        check("rst_alu_op", 32'(bus.alu_op_o), 32'(ALU_OP_ADD));
        check("rst_rd", 32'(bus.rd_addr_o), 32'd0);
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        step();
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);

        // ---------------- passthrough ----------------
        set_op(ALU_OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 2'd0, 2'd0, 32'h0, 32'h0, 5'd10);
        bus.in_valid_i = 1'b1;
        step();
        check("pass_valid", 32'(bus.out_valid_o), 32'd1);
        check("pass_in1", bus.in1_o, 32'd5);
        check("pass_in2", bus.in2_o, 32'd7);
        check("pass_op", 32'(bus.alu_op_o), 32'(ALU_OP_ADD));
        check("pass_rd", 32'(bus.rd_addr_o), 32'd10);

        // ---------------- forwarding (back-to-back, ONE reloads) ----------------
        set_op(ALU_OP_SUB, 5'd3, 32'd1, 5'd4, 32'd2, 2'd0, 2'd0, 32'h0, 32'h0, 5'd11);
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        step();
        check("fwd_mem_prio", bus.in1_o, 32'hAA);
        check("fwd_rs2_rf", bus.in2_o, 32'd2);
        check("fwd_op", 32'(bus.alu_op_o), 32'(ALU_OP_SUB));

        set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd3, 32'hBB);
        step();
        check("fwd_wb", bus.in1_o, 32'hBB);

        set_fwd(1'b0, 5'd3, 32'hAA, 1'b0, 5'd3, 32'hBB);
        step();
        check("fwd_disabled", bus.in1_o, 32'd1);

        set_op(ALU_OP_OR, 5'd0, 32'h55, 5'd4, 32'd2, 2'd0, 2'd0, 32'h0, 32'h0, 5'd12);
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        step();
        check("fwd_x0", bus.in1_o, 32'h0);

        set_op(ALU_OP_XOR, 5'd6, 32'h1, 5'd7, 32'h2, 2'd0, 2'd0, 32'h0, 32'h0, 5'd13);
        set_fwd(1'b1, 5'd7, 32'hCC, 1'b1, 5'd6, 32'hDD);
        step();
        check("fwd_split_in1", bus.in1_o, 32'hDD);
        check("fwd_split_in2", bus.in2_o, 32'hCC);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // ---------------- operand mux ----------------
        set_op(ALU_OP_ADD, 5'd1, 32'd9, 5'd2, 32'd9, 2'd1, 2'd2, 32'h100, 32'h0, 5'd1);
        step();
        check("mux_pc", bus.in1_o, 32'h100);
        check("mux_four", bus.in2_o, 32'd4);

        set_op(ALU_OP_ADD, 5'd1, 32'd9, 5'd2, 32'd9, 2'd2, 2'd1, 32'h100, 32'hFFFF_FFF0, 5'd1);
        step();
        check("mux_zero", bus.in1_o, 32'h0);
        check("mux_imm", bus.in2_o, 32'hFFFF_FFF0);

        set_op(ALU_OP_ADD, 5'd1, 32'd9, 5'd2, 32'd9, 2'd3, 2'd3, 32'h100, 32'h1234, 5'd1);
        step();
        check("mux_rsv1", bus.in1_o, 32'h0);
        check("mux_rsv2", bus.in2_o, 32'h0);

        bus.in_valid_i = 1'b0;
        step();
        check("drain_valid", 32'(bus.out_valid_o), 32'd0);

        // ---------------- backpressure A,B,C ----------------
        bus.out_ready_i = 1'b0;
        set_op(ALU_OP_AND, 5'd1, 32'hA1, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd21);
        bus.in_valid_i = 1'b1;
        step();
        check("bp_a_valid", 32'(bus.out_valid_o), 32'd1);
        check("bp_a_in1", bus.in1_o, 32'hA1);
        check("bp_a_ready", 32'(bus.in_ready_o), 32'd1);

        set_op(ALU_OP_SLL, 5'd1, 32'hB2, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd22);
        step();
        check("bp_full_ready", 32'(bus.in_ready_o), 32'd0);
        check("bp_hold_in1", bus.in1_o, 32'hA1);
        check("bp_hold_op", 32'(bus.alu_op_o), 32'(ALU_OP_AND));

        set_op(ALU_OP_SRL, 5'd1, 32'hC3, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd23);
        step();
        check("bp_c_stall_ready", 32'(bus.in_ready_o), 32'd0);
        check("bp_c_stall_in1", bus.in1_o, 32'hA1);
        check("bp_c_stall_rd", 32'(bus.rd_addr_o), 32'd21);

        bus.out_ready_i = 1'b1;
        step();
        check("bp_b_in1", bus.in1_o, 32'hB2);
        check("bp_b_rd", 32'(bus.rd_addr_o), 32'd22);
        check("bp_b_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        check("bp_c_in1", bus.in1_o, 32'hC3);
        check("bp_c_op", 32'(bus.alu_op_o), 32'(ALU_OP_SRL));
        bus.in_valid_i = 1'b0;
        step();
        check("bp_done_valid", 32'(bus.out_valid_o), 32'd0);

        // ---------------- flush in FULL ----------------
        bus.out_ready_i = 1'b0;
        set_op(ALU_OP_ADD, 5'd1, 32'hD4, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd24);
        bus.in_valid_i = 1'b1;
        step();
        set_op(ALU_OP_ADD, 5'd1, 32'hE5, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd25);
        step();
        check("fl_full_ready", 32'(bus.in_ready_o), 32'd0);
        set_op(ALU_OP_ADD, 5'd1, 32'hF6, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd26);
        bus.flush_i = 1'b1;
        step();
        check("fl_full_valid", 32'(bus.out_valid_o), 32'd0);
        check("fl_full_ready2", 32'(bus.in_ready_o), 32'd1);
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        check("fl_full_after", 32'(bus.out_valid_o), 32'd0);

        // ---------------- flush in ONE with a would-be accept ----------------
        bus.out_ready_i = 1'b0;
        set_op(ALU_OP_ADD, 5'd1, 32'h77, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd27);
        bus.in_valid_i = 1'b1;
        step();
        check("fl_one_loaded", bus.in1_o, 32'h77);
        set_op(ALU_OP_ADD, 5'd1, 32'h88, 5'd2, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0, 5'd28);
        bus.flush_i = 1'b1;
        step();
        check("fl_one_valid", 32'(bus.out_valid_o), 32'd0);
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        check("fl_one_dropped", 32'(bus.out_valid_o), 32'd0);

        // ---------------- async reset mid-stream ----------------
        bus.out_ready_i = 1'b0;
        set_op(ALU_OP_SUB, 5'd1, 32'h99, 5'd2, 32'h66, 2'd0, 2'd0, 32'h0, 32'h0, 5'd29);
        bus.in_valid_i = 1'b1;
        step();
        step();
        check("mid_full", 32'(bus.in_ready_o), 32'd0);
        #2 reset_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("mid_rst_in1", bus.in1_o, 32'h0);
        check("mid_rst_in2", bus.in2_o, 32'h0);
        bus.in_valid_i = 1'b0;
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        step();
        check("mid_rel_ready", 32'(bus.in_ready_o), 32'd1);
        check("mid_rel_valid", 32'(bus.out_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
